// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencer: state encoding,
// inactive strobe level, default phase length and the per-state bus drive table.
package rtc_bus_sequencer_pkg;

    localparam int   CICLOS_FASE_DEF = 10;
    localparam logic STROBE_INACTIVO = 1'b1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ADDR_SETUP  = 3'd1,
        ADDR_STROBE = 3'd2,
        ADDR_HOLD   = 3'd3,
        DATA_SETUP  = 3'd4,
        DATA_STROBE = 3'd5,
        DATA_HOLD   = 3'd6,
        DONE        = 3'd7
    } estado_e;

    typedef struct packed {
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_n;
        logic       ad_oe;
        logic [7:0] ad_out;
    } bus_drive_t;

    function automatic estado_e siguienteEstado(estado_e e);
        case (e)
            IDLE:        return ADDR_SETUP;
            ADDR_SETUP:  return ADDR_STROBE;
            ADDR_STROBE: return ADDR_HOLD;
            ADDR_HOLD:   return DATA_SETUP;
            DATA_SETUP:  return DATA_STROBE;
            DATA_STROBE: return DATA_HOLD;
            DATA_HOLD:   return DONE;
            default:     return IDLE;
        endcase
    endfunction

    // The address strobe always uses wr_n, even for reads; only the data phase
    // chooses between rd_n and wr_n.
    function automatic bus_drive_t busDrive(estado_e e, logic esEscritura,
                                            logic [7:0] dir, logic [7:0] dato);
        bus_drive_t b;
        b.cs_n   = STROBE_INACTIVO;
        b.rd_n   = STROBE_INACTIVO;
        b.wr_n   = STROBE_INACTIVO;
        b.ad_n   = STROBE_INACTIVO;
        b.ad_oe  = 1'b0;
        b.ad_out = 8'h00;
        case (e)
            ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
                b.cs_n   = 1'b0;
                b.ad_n   = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = dir;
                b.wr_n   = (e == ADDR_STROBE) ? 1'b0 : STROBE_INACTIVO;
            end
            DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
                b.cs_n = 1'b0;
                if (esEscritura) begin
                    b.ad_oe  = 1'b1;
                    b.ad_out = dato;
                    b.wr_n   = (e == DATA_STROBE) ? 1'b0 : STROBE_INACTIVO;
                end else begin
                    b.rd_n   = (e == DATA_STROBE) ? 1'b0 : STROBE_INACTIVO;
                end
            end
            default: ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_fase_timer.sv
// Phase down-counter: reloads on every state entry and flags the last cycle
// of a phase when it reaches zero.
module fase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       carga_i,
    input  logic       decrementa_i,
    input  logic [7:0] valor_i,
    output logic       fin_o
);

    logic [7:0] cuenta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta_q <= 8'd0;
        end else if (carga_i) begin
            cuenta_q <= valor_i;
        end else if (decrementa_i && (cuenta_q != 8'd0)) begin
            cuenta_q <= cuenta_q - 8'd1;
        end
    end

    assign fin_o = (cuenta_q == 8'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequences one read or write cycle on a multiplexed-address/data RTC bus,
// six timed phases followed by a one-cycle done pulse.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int CICLOS_FASE = CICLOS_FASE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arranque,
    input  logic       tipo,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escritura,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] dato_leido,
    output logic       ocupado,
    output logic       listo
);

    localparam logic [7:0] RECARGA = 8'(CICLOS_FASE - 1);

    estado_e    estado_q, estado_d;
    logic       tipo_q, tipo_d;
    logic [7:0] direccion_q, direccion_d;
    logic [7:0] dato_q, dato_d;
    logic       carga, decrementa, fin;
    bus_drive_t salida_d;

    fase_timer u_fase_timer (
        .clk          (clk),
        .rst          (rst),
        .carga_i      (carga),
        .decrementa_i (decrementa),
        .valor_i      (RECARGA),
        .fin_o        (fin)
    );

    // Outputs are registered from the next state and next latched values, so
    // the pins change on the same edge as the state.
    always_comb begin
        estado_d    = estado_q;
        tipo_d      = tipo_q;
        direccion_d = direccion_q;
        dato_d      = dato_q;
        carga       = 1'b0;
        decrementa  = 1'b0;
        case (estado_q)
            IDLE: begin
                if (arranque) begin
                    estado_d    = ADDR_SETUP;
                    tipo_d      = tipo;
                    direccion_d = direccion;
                    dato_d      = dato_escritura;
                    carga       = 1'b1;
                end
            end
            DONE: estado_d = IDLE;
            default: begin
                if (fin) begin
                    estado_d = siguienteEstado(estado_q);
                    carga    = 1'b1;
                end else begin
                    decrementa = 1'b1;
                end
            end
        endcase
        salida_d = busDrive(estado_d, tipo_d, direccion_d, dato_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= IDLE;
            tipo_q      <= 1'b0;
            direccion_q <= 8'h00;
            dato_q      <= 8'h00;
            dato_leido  <= 8'h00;
            ad_out      <= 8'h00;
            ad_oe       <= 1'b0;
            cs_n        <= STROBE_INACTIVO;
            rd_n        <= STROBE_INACTIVO;
            wr_n        <= STROBE_INACTIVO;
            ad_n        <= STROBE_INACTIVO;
            listo       <= 1'b0;
            ocupado     <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            tipo_q      <= tipo_d;
            direccion_q <= direccion_d;
            dato_q      <= dato_d;
            ad_out      <= salida_d.ad_out;
            ad_oe       <= salida_d.ad_oe;
            cs_n        <= salida_d.cs_n;
            rd_n        <= salida_d.rd_n;
            wr_n        <= salida_d.wr_n;
            ad_n        <= salida_d.ad_n;
            listo       <= (estado_d == DONE);
            ocupado     <= (estado_d != IDLE);
            if ((estado_q == DATA_STROBE) && fin && !tipo_q) begin
                dato_leido <= ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: a default-length instance and a
// one-cycle-phase instance share stimulus, with a start-flag register model.
module tb_rtc_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst, tipo, sel, flag, flagSet, flagClr;
    logic [7:0] direccion, dato_escritura, ad_in;
    logic       arranque10, arranque1;

    logic [7:0] ad_out10, dato_leido10, ad_out1, dato_leido1;
    logic       ad_oe10, cs_n10, rd_n10, wr_n10, ad_n10, ocupado10, listo10;
    logic       ad_oe1, cs_n1, rd_n1, wr_n1, ad_n1, ocupado1, listo1;

    logic [7:0] m_ad_out, m_dato_leido;
    logic       m_ad_oe, m_cs_n, m_rd_n, m_wr_n, m_ad_n, m_ocupado, m_listo;

    int checks = 0;
    int passed = 0;
    int listoCycle, listoCount, wrLow, wrRuns, rdLow, addrSeen, addrBad;
    int dataSeen, dataBad, conflicts, wrInData, busyAfter;
    logic [7:0] leidoAtListo;
    logic       ocupadoAfterListo;

    always #5 clk = ~clk;

    assign arranque10 = flag & ~sel;
    assign arranque1  = flag & sel;

    assign m_ad_out     = sel ? ad_out1     : ad_out10;
    assign m_dato_leido = sel ? dato_leido1 : dato_leido10;
    assign m_ad_oe      = sel ? ad_oe1      : ad_oe10;
    assign m_cs_n       = sel ? cs_n1       : cs_n10;
    assign m_rd_n       = sel ? rd_n1       : rd_n10;
    assign m_wr_n       = sel ? wr_n1       : wr_n10;
    assign m_ad_n       = sel ? ad_n1       : ad_n10;
    assign m_ocupado    = sel ? ocupado1    : ocupado10;
    assign m_listo      = sel ? listo1      : listo10;

    // Start-flag register: set by software, cleared by the done pulse.
    always @(posedge clk) begin
        if (flagClr || m_listo) flag <= 1'b0;
        else if (flagSet)       flag <= 1'b1;
    end

    rtc_bus_sequencer #(.CICLOS_FASE(10)) dut10 (
        .clk(clk), .rst(rst), .arranque(arranque10), .tipo(tipo),
        .direccion(direccion), .dato_escritura(dato_escritura), .ad_in(ad_in),
        .ad_out(ad_out10), .ad_oe(ad_oe10), .cs_n(cs_n10), .rd_n(rd_n10),
        .wr_n(wr_n10), .ad_n(ad_n10), .dato_leido(dato_leido10),
        .ocupado(ocupado10), .listo(listo10)
    );

    rtc_bus_sequencer #(.CICLOS_FASE(1)) dut1 (
        .clk(clk), .rst(rst), .arranque(arranque1), .tipo(tipo),
        .direccion(direccion), .dato_escritura(dato_escritura), .ad_in(ad_in),
        .ad_out(ad_out1), .ad_oe(ad_oe1), .cs_n(cs_n1), .rd_n(rd_n1),
        .wr_n(wr_n1), .ad_n(ad_n1), .dato_leido(dato_leido1),
        .ocupado(ocupado1), .listo(listo1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the IDLE cycle in which the DUT sees arranque=1; cycle k is
    // sampled k edges later.
    task automatic applyStimulus(input logic selDut, input logic t, input logic [7:0] dir,
                                 input logic [7:0] dat, input logic [7:0] rdVal,
                                 input int window, input bit scramble);
        logic prevWr;
        sel = selDut; tipo = t; direccion = dir; dato_escritura = dat; ad_in = 8'hFF;
        listoCycle = -1; listoCount = 0; wrLow = 0; wrRuns = 0; rdLow = 0;
        addrSeen = 0; addrBad = 0; dataSeen = 0; dataBad = 0; conflicts = 0;
        wrInData = 0; busyAfter = 0; leidoAtListo = 8'h00; ocupadoAfterListo = 1'b1;
        flagSet = 1'b1;
        stepCycle();
        flagSet = 1'b0;
        prevWr = 1'b1;
        for (int k = 1; k <= window; k++) begin
            stepCycle();
            if (scramble && k == 2) begin
                tipo = ~t; direccion = ~dir; dato_escritura = ~dat;
            end
            if (listoCycle >= 0 && k == listoCycle + 1) ocupadoAfterListo = m_ocupado;
            if (listoCycle >= 0 && k > listoCycle && m_ocupado) busyAfter++;
            if (m_listo) begin
                listoCount++;
                if (listoCycle < 0) begin
                    listoCycle = k;
                    leidoAtListo = m_dato_leido;
                end
            end
            if (!m_wr_n) wrLow++;
            if (!m_wr_n && prevWr) wrRuns++;
            prevWr = m_wr_n;
            if (!m_rd_n) rdLow++;
            if (!m_rd_n && !m_wr_n) conflicts++;
            if (!m_rd_n && m_ad_oe) conflicts++;
            if (!m_cs_n && !m_ad_n) begin
                addrSeen++;
                if (!m_ad_oe || m_ad_out !== dir) addrBad++;
            end
            if (!m_cs_n && m_ad_n) begin
                dataSeen++;
                if (t ? (!m_ad_oe || m_ad_out !== dat) : m_ad_oe) dataBad++;
                if (!m_wr_n) wrInData++;
            end
            ad_in = !m_rd_n ? rdVal : 8'hFF;
        end
    endtask

    initial begin
        rst = 1'b1; flagClr = 1'b1; flagSet = 1'b0; sel = 1'b0; tipo = 1'b0;
        direccion = 8'h00; dato_escritura = 8'h00; ad_in = 8'h00;
        stepCycle();
        stepCycle();
        checkOutput("rst_cs_n", cs_n10, 1);
        checkOutput("rst_rd_n", rd_n10, 1);
        checkOutput("rst_wr_n", wr_n10, 1);
        checkOutput("rst_ad_n", ad_n10, 1);
        checkOutput("rst_ad_oe", ad_oe10, 0);
        checkOutput("rst_ad_out", ad_out10, 0);
        checkOutput("rst_listo", listo10, 0);
        checkOutput("rst_ocupado", ocupado10, 0);
        checkOutput("rst_dato_leido", dato_leido10, 0);
        rst = 1'b0; flagClr = 1'b0;
        stepCycle();

        $display("[TB] write N=10 addr 0x21 data 0x45");
        applyStimulus(1'b0, 1'b1, 8'h21, 8'h45, 8'h00, 70, 1'b0);
        checkOutput("wr_latency", listoCycle, 61);
        checkOutput("wr_listo_count", listoCount, 1);
        checkOutput("wr_wr_low", wrLow, 20);
        checkOutput("wr_wr_runs", wrRuns, 2);
        checkOutput("wr_rd_low", rdLow, 0);
        checkOutput("wr_addr_cycles", addrSeen, 30);
        checkOutput("wr_addr_bad", addrBad, 0);
        checkOutput("wr_data_cycles", dataSeen, 30);
        checkOutput("wr_data_bad", dataBad, 0);
        checkOutput("wr_conflicts", conflicts, 0);
        checkOutput("wr_ocupado_after", ocupadoAfterListo, 0);
        checkOutput("wr_no_restart", busyAfter, 0);

        $display("[TB] read N=10 addr 0x22 ad_in 0x37");
        applyStimulus(1'b0, 1'b0, 8'h22, 8'h00, 8'h37, 70, 1'b0);
        checkOutput("rd_latency", listoCycle, 61);
        checkOutput("rd_listo_count", listoCount, 1);
        checkOutput("rd_dato_leido", leidoAtListo, 8'h37);
        checkOutput("rd_rd_low", rdLow, 10);
        checkOutput("rd_wr_low", wrLow, 10);
        checkOutput("rd_wr_in_data", wrInData, 0);
        checkOutput("rd_data_oe", dataBad, 0);
        checkOutput("rd_addr_bad", addrBad, 0);
        checkOutput("rd_conflicts", conflicts, 0);

        $display("[TB] write keeps previous read data");
        applyStimulus(1'b0, 1'b1, 8'h30, 8'h5A, 8'h00, 70, 1'b0);
        checkOutput("wr2_latency", listoCycle, 61);
        checkOutput("wr2_data_bad", dataBad, 0);
        checkOutput("wr2_dato_leido_held", dato_leido10, 8'h37);

        $display("[TB] reset during DATA_STROBE of a write");
        sel = 1'b0; tipo = 1'b1; direccion = 8'h40; dato_escritura = 8'h99;
        flagSet = 1'b1;
        stepCycle();
        flagSet = 1'b0;
        for (int k = 1; k <= 45; k++) stepCycle();
        checkOutput("abort_in_strobe_wr_n", wr_n10, 0);
        rst = 1'b1; flagClr = 1'b1;
        stepCycle();
        rst = 1'b0; flagClr = 1'b0;
        checkOutput("abort_cs_n", cs_n10, 1);
        checkOutput("abort_rd_n", rd_n10, 1);
        checkOutput("abort_wr_n", wr_n10, 1);
        checkOutput("abort_ad_n", ad_n10, 1);
        checkOutput("abort_ad_oe", ad_oe10, 0);
        checkOutput("abort_ocupado", ocupado10, 0);
        checkOutput("abort_dato_leido", dato_leido10, 0);
        listoCount = 0;
        for (int k = 0; k < 30; k++) begin
            if (listo10) listoCount++;
            stepCycle();
        end
        checkOutput("abort_no_listo", listoCount, 0);
        applyStimulus(1'b0, 1'b1, 8'h11, 8'h22, 8'h00, 70, 1'b0);
        checkOutput("after_abort_latency", listoCycle, 61);
        checkOutput("after_abort_data_bad", dataBad, 0);

        $display("[TB] write N=1 with inputs changed mid-transaction");
        applyStimulus(1'b1, 1'b1, 8'h21, 8'h45, 8'h00, 12, 1'b1);
        checkOutput("n1_latency", listoCycle, 7);
        checkOutput("n1_listo_count", listoCount, 1);
        checkOutput("n1_addr_cycles", addrSeen, 3);
        checkOutput("n1_addr_bad", addrBad, 0);
        checkOutput("n1_data_bad", dataBad, 0);
        checkOutput("n1_wr_low", wrLow, 2);
        checkOutput("n1_rd_low", rdLow, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
